// File: rtl/seq_mult_param.sv
// seq_mult_param: shift-add sequential multiplier, WIDTH-bit operands,
// per-operation signed/unsigned mode, busy/valid handshake.
//
// Ports:
//   clock        rising-edge clock
//   reset_n      synchronous reset, active-low
//   start        request, sampled only while idle (IDLE/DONE)
//   signed_mode  1 = two's-complement operands, 0 = unsigned
//   mcand/mlier  WIDTH-bit operands, latched on an accepted start
//   busy         high while an operation is in flight
//   valid        product valid, held until the next accepted start
//   product      2*WIDTH-bit result
module seq_mult_param #(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mlier,
    output logic                 busy,
    output logic                 valid,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH:0]       acc_q, acc_d;
    logic [WIDTH-1:0]     low_q, low_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     mcand_abs;
    logic [WIDTH-1:0]     mlier_abs;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   mag;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            low_q     <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            low_q     <= low_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        low_d     = low_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        product_d = product_q;

        // Magnitudes; the most negative value maps to 2^(W-1),
        // which still fits in WIDTH unsigned bits.
        mcand_abs = (signed_mode && mcand[WIDTH-1]) ? -mcand : mcand;
        mlier_abs = (signed_mode && mlier[WIDTH-1]) ? -mlier : mlier;

        // acc_q[WIDTH] is always 0 after a shift, so the carry
        // out of the WIDTH-bit add lands in sum[WIDTH].
        sum = acc_q + (low_q[0] ? {1'b0, mcand_q} : '0);
        mag = {acc_q[WIDTH-1:0], low_q};

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mcand_d = mcand_abs;
                    low_d   = mlier_abs;
                    acc_d   = '0;
                    neg_d   = signed_mode & (mcand[WIDTH-1] ^ mlier[WIDTH-1]);
                    cnt_d   = CNT_W'(WIDTH);
                    valid_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = {1'b0, sum[WIDTH:1]};
                low_d = {sum[0], low_q[WIDTH-1:1]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // Negating a zero magnitude yields zero, so no -0.
                product_d = neg_q ? -mag : mag;
                valid_d   = 1'b1;
                busy_d    = 1'b0;
                state_d   = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = busy_q;
    assign valid   = valid_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: directed vectors at WIDTH=8 plus a
// randomised signed/unsigned sweep at WIDTH=16.
module tb_seq_mult_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        st8 = 1'b0;
    logic        sm8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8;
    logic        valid8;
    logic [15:0] p8;

    logic        st16 = 1'b0;
    logic        sm16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        busy16;
    logic        valid16;
    logic [31:0] p16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_mult_param #(.WIDTH(8)) u8 (
        .clock       (clk),
        .reset_n     (rst_n),
        .start       (st8),
        .signed_mode (sm8),
        .mcand       (a8),
        .mlier       (b8),
        .busy        (busy8),
        .valid       (valid8),
        .product     (p8)
    );

    seq_mult_param #(.WIDTH(16)) u16 (
        .clock       (clk),
        .reset_n     (rst_n),
        .start       (st16),
        .signed_mode (sm16),
        .mcand       (a16),
        .mlier       (b16),
        .busy        (busy16),
        .valid       (valid16),
        .product     (p16)
    );

    typedef struct {
        string       nm;
        logic        sm;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Issue a one-cycle start; returns at the negedge after the
    // accepting edge.
    task automatic op8(input logic sm, input logic [7:0] a,
                       input logic [7:0] b);
        @(negedge clk);
        sm8 = sm;
        a8  = a;
        b8  = b;
        st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
    endtask

    // Called at the negedge after the accepting edge (lat=0);
    // counts edges until valid and busy samples on the way.
    task automatic wait8(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!valid8 && lat < 40) begin
            if (busy8) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    function automatic logic [31:0] ref16(input logic sm,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
        logic [31:0] ea;
        logic [31:0] eb;
        ea = sm ? {{16{a[15]}}, a} : {16'h0, a};
        eb = sm ? {{16{b[15]}}, b} : {16'h0, b};
        return ea * eb;
    endfunction

    initial begin
        int lat;
        int bcnt;
        int op_lat;

        vecs[0]  = '{"u_ff_ff",   1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[1]  = '{"s_m128sq",  1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[2]  = '{"s_m1x1",    1'b1, 8'hFF, 8'h01, 16'hFFFF};
        vecs[3]  = '{"s_127xm128",1'b1, 8'h7F, 8'h80, 16'hC080};
        vecs[4]  = '{"u_ffx2",    1'b0, 8'hFF, 8'h02, 16'h01FE};
        vecs[5]  = '{"s_ffx2",    1'b1, 8'hFF, 8'h02, 16'hFFFE};
        vecs[6]  = '{"s_0xm128",  1'b1, 8'h00, 8'h80, 16'h0000};
        vecs[7]  = '{"u_0x0",     1'b0, 8'h00, 8'h00, 16'h0000};
        vecs[8]  = '{"s_m128x127",1'b1, 8'h80, 8'h7F, 16'hC080};
        vecs[9]  = '{"u_80x80",   1'b0, 8'h80, 8'h80, 16'h4000};
        vecs[10] = '{"s_5xm3",    1'b1, 8'h05, 8'hFD, 16'hFFF1};
        vecs[11] = '{"u_3x5",     1'b0, 8'h03, 8'h05, 16'h000F};

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy8}, 32'd0);
        chk("rst_valid", {31'b0, valid8}, 32'd0);
        chk("rst_product", {16'b0, p8}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            op8(vecs[i].sm, vecs[i].a, vecs[i].b);
            chk({vecs[i].nm, "_vdrop"}, {31'b0, valid8}, 32'd0);
            wait8(lat, bcnt);
            chk({vecs[i].nm, "_lat"}, lat, 32'd9);
            chk({vecs[i].nm, "_busy"}, bcnt, 32'd9);
            chk({vecs[i].nm, "_prod"}, {16'b0, p8}, {16'b0, vecs[i].exp});
            repeat (3) @(negedge clk);
            chk({vecs[i].nm, "_hold"}, {15'b0, valid8, p8},
                {15'b0, 1'b1, vecs[i].exp});
        end

        // Operand and mode changes during CALC are ignored.
        op8(1'b0, 8'hFF, 8'h02);
        sm8 = 1'b1;
        a8  = 8'h80;
        b8  = 8'h80;
        st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        @(negedge clk);
        wait8(lat, bcnt);
        chk("toggle_prod", {16'b0, p8}, 32'h01FE);

        // start held high: back-to-back operations.
        @(negedge clk);
        sm8 = 1'b0;
        a8  = 8'd3;
        b8  = 8'd5;
        st8 = 1'b1;
        @(negedge clk);
        a8 = 8'd7;
        b8 = 8'd9;
        wait8(lat, bcnt);
        chk("b2b_lat1", lat, 32'd9);
        chk("b2b_prod1", {16'b0, p8}, 32'h000F);
        @(negedge clk);
        chk("b2b_accept", {30'b0, busy8, valid8}, 32'h2);
        wait8(lat, bcnt);
        st8 = 1'b0;
        chk("b2b_lat2", lat, 32'd9);
        chk("b2b_prod2", {16'b0, p8}, 32'h003F);

        // Reset in the middle of CALC.
        op8(1'b0, 8'd200, 8'd3);
        repeat (3) @(negedge clk);
        chk("mid_prod_held", {16'b0, p8}, 32'h003F);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_state", {14'b0, busy8, valid8, p8}, 32'd0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_quiet", {14'b0, busy8, valid8, p8}, 32'd0);
        op8(1'b0, 8'd6, 8'd7);
        wait8(lat, bcnt);
        chk("after_rst_lat", lat, 32'd9);
        chk("after_rst_prod", {16'b0, p8}, 32'h002A);

        // WIDTH=16 sweep against the reference model.
        for (int n = 0; n < 1000; n++) begin
            logic        sm;
            logic [15:0] a;
            logic [15:0] b;
            logic [31:0] exp;
            sm = 1'($urandom_range(0, 1));
            a  = 16'($urandom);
            b  = 16'($urandom);
            case ($urandom_range(0, 7))
                0: a = 16'h8000;
                1: b = 16'h8000;
                2: a = 16'h0000;
                3: b = 16'hFFFF;
                default: ;
            endcase
            exp = ref16(sm, a, b);
            @(negedge clk);
            sm16 = sm;
            a16  = a;
            b16  = b;
            st16 = 1'b1;
            @(negedge clk);
            st16   = 1'b0;
            op_lat = 0;
            while (!valid16 && op_lat < 60) begin
                @(negedge clk);
                op_lat++;
            end
            chk($sformatf("w16_lat_%0d", n), op_lat, 32'd17);
            chk($sformatf("w16_prod_%0d", n), p16, exp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
